muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide execution unit with HI/LO result registers for the Antares-R2 processor. It executes the MUL/DIV class operations that the control unit issues, serves MFHI/MFLO reads and MTHI/MTLO writes, and raises `busy` so the pipeline stalls while an operation is in flight. It sits in the EX stage beside the ALU and connects directly to the register file read ports.

## Interface

Parameters:
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight; stall request.
- `done`  out  1  one-cycle pulse when HI/LO take the new result.
- `div_zero`  out  1  sticky flag; last divide had `b`=0.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).

## Operation

- States: IDLE, CALC, FINISH.
- IDLE, `start`=1: latch operands, op and zeroed accumulator; counter = WIDTH-1; go to CALC.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter decrements. At 0, go to FINISH.
- FINISH: write HI/LO, pulse `done`, go to IDLE.
- Multiply: {HI,LO} = full 2·WIDTH product.
- Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = `a`, `div_zero`=1. Takes the same latency. `div_zero` clears on the next divide with a nonzero `b`. Multiplies do not change it.
- `start` while `busy`=1 is ignored. Nothing is queued.
- `hi_we`/`lo_we` in IDLE write the register on the next edge. While `busy`=1 they are ignored.
- The FINISH write always wins over an MTHI/MTLO in the same cycle.
- `reset` in any state, including mid-CALC: next state is IDLE. `busy`, `done`, `div_zero`, `hi`, `lo` and the internal state all become 0. The aborted operation produces no `done`.

## Timing

- `start` sampled high at edge of cycle N.
- `busy`=1 during cycles N+1 through N+33. That is 32 CALC cycles plus 1 FINISH cycle.
- `done`=1 only in cycle N+33.
- `hi`/`lo` show the new result from cycle N+34.
- `busy`=0 from N+34, so a back-to-back `start` is accepted in N+34.
- `busy` is registered. There is no combinational path from `start` to `busy`, so the stall takes effect one cycle after issue.
- MTHI/MTLO: value visible on `hi`/`lo` in the cycle after the strobe.
- Reset values: all outputs 0.

## Configuration

- Macro: `MULDIV_SIGNED_EN`.
- Defined: `op[1]`=1 selects signed MULT/DIV.
  - Operands are converted to magnitude on entry to CALC.
  - Signs are applied in FINISH.
  - Quotient is negative when operand signs differ; remainder takes the sign of the dividend.
  - Latency is unchanged.
- Not defined: `op[1]` is ignored and all operations are unsigned. No sign logic is synthesized.

## Structure

- Shared package `muldiv_pkg`:
  - op encodings `OP_MULTU`, `OP_DIVU`, `OP_MULT`, `OP_DIV`;
  - state encodings `ST_IDLE`, `ST_CALC`, `ST_FINISH`;
  - default `MULDIV_WIDTH` = 32.
- One sub-module, `muldiv_step`: combinational single iteration. Inputs are accumulator, operand and mode; outputs are the next accumulator and quotient bit. Instantiated once; the top level holds the FSM, counter and HI/LO registers.

## Test plan

- MULTU `a`=0xFFFFFFFF, `b`=2, start at N -> `done` at N+33; `hi`=0x00000001, `lo`=0xFFFFFFFE; `busy` high N+1..N+33.
- DIVU `a`=100, `b`=7 -> `lo`=14, `hi`=2, `div_zero`=0.
- DIVU `a`=5, `b`=0 -> `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1. A following DIVU 9/3 -> `lo`=3, `hi`=0, `div_zero`=0.
- Busy collisions:
  - MULTU 3×4 at N, second `start` (DIVU 8/2) at N+5, `hi_we` with 0xAA at N+10 -> single `done` at N+33; `hi`=0, `lo`=12.
  - After return to IDLE, `lo_we` with 0x55 -> `lo`=0x55 next cycle.
- `reset` at N+10 of a DIVU -> cycle N+11: `busy`=0, `hi`=`lo`=0. No `done` pulse follows. A new `start` in N+11 is accepted.
- With `MULDIV_SIGNED_EN`:
  - DIV -7/2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - MULT -3×4 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4.
  - Without the macro, the same op=11 stimulus gives the unsigned result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the Antares-R2 multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] operand,
  input  logic             div_mode,
  output logic [WIDTH-1:0] acc_next,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (bit_in ? {1'b0, operand} : '0);
    rem  = {acc, bit_in};
    diff = rem - {1'b0, operand};
    if (div_mode) begin
      // acc < divisor holds between steps, so diff fits WIDTH bits when non-negative
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_bit    = 1'b1;
      end else begin
        acc_next = rem[WIDTH-1:0];
        q_bit    = 1'b0;
      end
    end else begin
      acc_next = sum[WIDTH:1];
      q_bit    = sum[0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV unit with HI/LO registers; WIDTH steps plus one FINISH cycle.
// Optional signed MULT/DIV support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opq;
  logic [WIDTH-1:0] opb;
  logic             is_div;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0] acc_next;
  logic             q_bit;
  logic             step_bit;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sgn;

  always_comb begin
    sgn   = op[1];
    a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  end
`else
  logic op_unused;
  assign op_unused = op[1];

  always_comb begin
    a_mag = a;
    b_mag = b;
  end
`endif

  assign step_bit = is_div ? opq[WIDTH-1] : opq[0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .bit_in   (step_bit),
    .operand  (opb),
    .div_mode (is_div),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_CALC;
      ST_CALC:   if (cnt == '0) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_FINISH);
  end

  // Magnitude results are sign-corrected here so FINISH writes the final value.
  always_comb begin
    prod = {acc, opq};
    quo  = opq;
    rem  = acc;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_r) rem = -rem;
`endif
    if (b_zero) quo = '1;
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opq      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt    <= CW'(WIDTH - 1);
            acc    <= '0;
            opq    <= a_mag;
            opb    <= b_mag;
            is_div <= op[0];
            b_zero <= op[0] && (b == '0);
`ifdef MULDIV_SIGNED_EN
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn && op[0] && a[WIDTH-1];
`endif
          end
        end
        ST_CALC: begin
          cnt <= cnt - 1'b1;
          acc <= acc_next;
          if (is_div) opq <= {opq[WIDTH-2:0], q_bit};
          else        opq <= {q_bit, opq[WIDTH-1:1]};
        end
        ST_FINISH: begin
          hi <= res_hi;
          lo <= res_lo;
          if (is_div) div_zero <= b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (signed expectations follow MULDIV_SIGNED_EN).
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op in the current cycle (N) and tracks busy/done through N+33.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit collide);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      chk("busy_inflight", {31'b0, busy}, 32'd1);
      chk("done_timing", {31'b0, done}, (i == 33) ? 32'd1 : 32'd0);
      if (collide) begin
        case (i)
          5:  begin start = 1'b1; op = 2'b01; a = 32'd8; b = 32'd2; end
          6:  start = 1'b0;
          10: begin hi_we = 1'b1; wdata = 32'hAA; end
          11: hi_we = 1'b0;
          default: ;
        endcase
      end
      tick();
    end
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("done_after", {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    run_op(2'b01, 32'd100, 32'd7, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_dz", {31'b0, div_zero}, 32'd0);

    run_op(2'b01, 32'd5, 32'd0, 1'b0);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'd5);
    chk("dz_flag", {31'b0, div_zero}, 32'd1);

    run_op(2'b00, 32'd3, 32'd3, 1'b0);
    chk("mul_keep_dz", {31'b0, div_zero}, 32'd1);
    chk("mul9_lo", lo, 32'd9);

    run_op(2'b01, 32'd9, 32'd3, 1'b0);
    chk("div93_lo", lo, 32'd3);
    chk("div93_hi", hi, 32'd0);
    chk("dz_clear", {31'b0, div_zero}, 32'd0);

    run_op(2'b01, 32'hFFFFFFFF, 32'd1, 1'b0);
    chk("divmax_lo", lo, 32'hFFFFFFFF);
    chk("divmax_hi", hi, 32'd0);

    run_op(2'b00, 32'd3, 32'd4, 1'b1);
    chk("coll_hi", hi, 32'd0);
    chk("coll_lo", lo, 32'd12);
    tick();
    chk("coll_nostart", {31'b0, busy}, 32'd0);

    lo_we = 1'b1; wdata = 32'h55;
    tick();
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_hi", hi, 32'd0);

    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h1234);

    // reset asserted in cycle N+10 of a DIVU
    op = 2'b01; a = 32'd100; b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_dz", {31'b0, div_zero}, 32'd0);
    run_op(2'b00, 32'd6, 32'd7, 1'b0);
    chk("post_abort_lo", lo, 32'd42);
    chk("post_abort_hi", hi, 32'd0);
    chk("post_abort_dz", {31'b0, div_zero}, 32'd0);

    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0);
`ifdef MULDIV_SIGNED_EN
    chk("div_s_lo", lo, 32'hFFFFFFFD);
    chk("div_s_hi", hi, 32'hFFFFFFFF);
`else
    chk("div_u_lo", lo, 32'h7FFFFFFC);
    chk("div_u_hi", hi, 32'h00000001);
`endif

    run_op(2'b10, 32'hFFFFFFFD, 32'd4, 1'b0);
`ifdef MULDIV_SIGNED_EN
    chk("mult_s_hi", hi, 32'hFFFFFFFF);
    chk("mult_s_lo", lo, 32'hFFFFFFF4);
`else
    chk("mult_u_hi", hi, 32'h00000003);
    chk("mult_u_lo", lo, 32'hFFFFFFF4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
